if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
Parametrised instruction-fetch stage that replaces the single-entry IF register with a DEPTH-entry {PC, Inst} queue. It drives the fetch PC to instruction memory and enqueues each returned word with its PC. It presents the queue head to ID through a valid/ready handshake. Exception flush and branch redirect steer the PC and purge the queue.

Parameters:
RESET_PC, 32'h1C000000, PC value loaded on reset
DEPTH, 4, queue entries; power of two, >= 2
PC_W, 32, PC width
INST_W, 32, instruction width
PTR_W, $clog2(DEPTH), derived; read/write pointer width

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
excp_flush  in  1  exception flush; highest priority
eentry  in  PC_W  exception entry address
is_branch  in  1  branch/jump redirect from a later stage
dnpc  in  PC_W  redirect target
PC  out  PC_W  current fetch address to instruction memory
Inst  in  INST_W  instruction at PC, combinational same cycle
inst_valid  in  1  Inst is valid this cycle (memory not stalled)
fetch_req  out  1  fetch is attempted this cycle
right_valid  out  1  queue head valid to ID
right_ready  in  1  ID accepts the head
data_bus  out  PC_W+INST_W  head entry, {PC[PC_W+INST_W-1:INST_W], Inst[INST_W-1:0]}
occupancy  out  PTR_W+1  number of valid entries

Behaviour:
- Reset: PC=RESET_PC; wr_ptr=rd_ptr=0; occupancy=0; right_valid=0; fetch_req=0. Queue storage is not cleared. data_bus is don't-care while right_valid=0.
- deq = right_valid & right_ready.
- full = (occupancy==DEPTH).
- fetch_req = !reset & !excp_flush & !is_branch & (!full | deq).
- enq = fetch_req & inst_valid.
- On enq:
  - mem[wr_ptr] <= {PC, Inst}
  - wr_ptr <= wr_ptr+1 (wraps modulo DEPTH)
  - PC <= PC + 4, modulo 2^PC_W
- On deq: rd_ptr <= rd_ptr+1 (wraps modulo DEPTH).
- occupancy updates next cycle: +1 on enq only, -1 on deq only, unchanged on both.
- Full with simultaneous deq: enq is permitted; occupancy stays DEPTH.
- Empty: right_valid=0, and no deq is possible. There is no bypass, so enq-to-head latency is 1 cycle.
- fetch_req=1 with inst_valid=0: PC holds and nothing is enqueued. Retry happens the next cycle.
- Priority, highest first: reset > excp_flush > is_branch > normal operation.
- excp_flush:
  - next cycle PC=eentry; pointers=0; occupancy=0; right_valid=0.
  - Inst in the flush cycle is discarded.
  - A deq asserted in the flush cycle has no effect beyond the purge.
- is_branch (without excp_flush): same as excp_flush, with PC=dnpc.
- excp_flush and is_branch together: eentry wins.
- Targets are used as given. Word alignment is the producer's responsibility, and PC[1:0] is never modified.
- Reset asserted mid-operation: identical to the reset state next cycle, regardless of other inputs.
- right_valid = (occupancy != 0). It is registered-state derived with no combinational path from any input.
- data_bus = mem[rd_ptr]. It must stay stable while right_valid & !right_ready, unless a flush occurs.
- DEPTH=2 must work; there are no special cases per DEPTH.
- State elements: PC register, pointers, occupancy counter, DEPTH x (PC_W+INST_W) storage. There is no other FSM.

Test Plan:
- Reset, then release with inst_valid=1 and right_ready=1:
  - cycle 0: PC=1C000000.
  - cycle 1: right_valid=1, data_bus={1C000000, Inst0}.
  - Thereafter PC advances by 4 every cycle and occupancy holds at 1.
- right_ready=0 with inst_valid=1 and DEPTH=4:
  - after 4 enqueues occupancy=4, fetch_req=0, PC=1C000010.
  - raise right_ready: heads come out 1C000000, 1C000004, ... in order; pointers wrap correctly past entry 3.
- Full queue, deq and inst_valid in the same cycle: occupancy stays 4, the new entry {1C000010, I} is enqueued, and PC becomes 1C000014.
- occupancy=3, then is_branch=1 with dnpc=1C000100:
  - next cycle right_valid=0 and occupancy=0.
  - PC=1C000100, and the first post-flush head is {1C000100, Inst}.
- excp_flush=1 with eentry=1C008000 together with is_branch=1 and dnpc=1C000100: PC=1C008000 and the queue is empty.
- inst_valid toggles 1,0,1,0 with right_ready=1: enqueues occur only on inst_valid=1 cycles, PC steps 1C000000 to 1C000004 to 1C000008 with no duplicate or missing PCs, and reset asserted mid-stream returns PC to 1C000000 with occupancy=0.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage with a DEPTH-entry {PC, Inst} queue in front of ID.
// Ports: clk/reset, excp_flush+eentry, is_branch+dnpc redirect, PC/Inst/inst_valid
// to instruction memory, fetch_req, right_valid/right_ready/data_bus to ID, occupancy.
module if_fetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                PC_W     = 32,
    parameter int                INST_W   = 32,
    parameter logic [PC_W-1:0]   RESET_PC = 32'h1C000000,
    localparam int               PTR_W    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     excp_flush,
    input  logic [PC_W-1:0]          eentry,
    input  logic                     is_branch,
    input  logic [PC_W-1:0]          dnpc,
    output logic [PC_W-1:0]          PC,
    input  logic [INST_W-1:0]        Inst,
    input  logic                     inst_valid,
    output logic                     fetch_req,
    output logic                     right_valid,
    input  logic                     right_ready,
    output logic [PC_W+INST_W-1:0]   data_bus,
    output logic [PTR_W:0]           occupancy
);

    logic [PC_W-1:0]         r_pc;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [PTR_W:0]          r_occ;
    logic [PC_W+INST_W-1:0]  r_mem [DEPTH];

    logic w_full;
    logic w_deq;
    logic w_enq;

    assign w_full      = (r_occ == (PTR_W+1)'(DEPTH));
    assign right_valid = (r_occ != '0);
    assign w_deq       = right_valid & right_ready;

    // A full queue may still fetch when the head leaves in the same cycle.
    assign fetch_req = !reset & !excp_flush & !is_branch & (!w_full | w_deq);
    assign w_enq     = fetch_req & inst_valid;

    assign PC        = r_pc;
    assign occupancy = r_occ;
    assign data_bus  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (excp_flush) begin
            r_pc     <= eentry;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (is_branch) begin
            r_pc     <= dnpc;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_enq) begin
                r_pc     <= r_pc + PC_W'(4);
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_enq, w_deq})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Storage is never cleared; w_enq is already gated by reset and flushes.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= {r_pc, Inst};
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized and directed bench for if_fetch_queue against a queue-based model.
// Reports each mismatch and prints a single summary line.
module tb_if_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h1C000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        excp_flush;
    logic [31:0] eentry;
    logic        is_branch;
    logic [31:0] dnpc;
    logic [31:0] PC;
    logic [31:0] Inst;
    logic        inst_valid;
    logic        fetch_req;
    logic        right_valid;
    logic        right_ready;
    logic [63:0] data_bus;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_pc;
    logic [63:0] m_q[$];

    always #5 clk = ~clk;

    if_fetch_queue #(
        .DEPTH(DEPTH), .PC_W(32), .INST_W(32), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk), .reset(reset), .excp_flush(excp_flush), .eentry(eentry),
        .is_branch(is_branch), .dnpc(dnpc), .PC(PC), .Inst(Inst),
        .inst_valid(inst_valid), .fetch_req(fetch_req),
        .right_valid(right_valid), .right_ready(right_ready),
        .data_bus(data_bus), .occupancy(occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare against the model, then advance the model.
    task automatic step(input bit rst, input bit fl, input bit br,
                        input bit iv, input bit rdy,
                        input logic [31:0] ee, input logic [31:0] dn,
                        input logic [31:0] ins);
        bit e_rv, e_full, e_deq, e_freq, e_enq;
        @(negedge clk);
        reset = rst; excp_flush = fl; is_branch = br;
        inst_valid = iv; right_ready = rdy;
        eentry = ee; dnpc = dn; Inst = ins;
        #1;
        e_rv   = (m_q.size() != 0);
        e_full = (m_q.size() == DEPTH);
        e_deq  = e_rv && rdy;
        e_freq = !rst && !fl && !br && (!e_full || e_deq);
        e_enq  = e_freq && iv;
        chk("pc", 64'(PC), 64'(m_pc));
        chk("fetch_req", 64'(fetch_req), 64'(e_freq));
        chk("right_valid", 64'(right_valid), 64'(e_rv));
        chk("occupancy", 64'(occupancy), 64'(m_q.size()));
        if (e_rv) chk("data_bus", data_bus, m_q[0]);
        @(posedge clk);
        if (rst) begin
            m_pc = RST_PC; m_q.delete();
        end else if (fl) begin
            m_pc = ee; m_q.delete();
        end else if (br) begin
            m_pc = dn; m_q.delete();
        end else begin
            if (e_deq) void'(m_q.pop_front());
            if (e_enq) begin
                m_q.push_back({m_pc, ins});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic run(input bit iv, input bit rdy, input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, iv, rdy, 32'h0, 32'h0, $urandom);
    endtask

    initial begin
        reset = 1'b1; excp_flush = 1'b0; is_branch = 1'b0;
        inst_valid = 1'b0; right_ready = 1'b0;
        eentry = '0; dnpc = '0; Inst = '0;
        m_pc = RST_PC;
        @(posedge clk);
        step(1, 0, 0, 1, 1, 0, 0, 0);
        #1;
        chk("pc_rst", 64'(PC), 64'h1C000000);
        chk("occ_rst", 64'(occupancy), 64'd0);
        chk("rv_rst", 64'(right_valid), 64'd0);

        // Streaming with ID always ready.
        run(1, 1, 6);
        #1;
        chk("occ_stream", 64'(occupancy), 64'd1);
        chk("pc_stream", 64'(PC), 64'h1C000018);

        // Fill to full, then full + deq + enq in one cycle.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        run(1, 0, 4);
        #1;
        chk("occ_full", 64'(occupancy), 64'd4);
        chk("pc_full", 64'(PC), 64'h1C000010);
        run(1, 0, 1);
        step(0, 0, 0, 1, 1, 0, 0, 32'hDEADBEEF);
        #1;
        chk("occ_full_deq", 64'(occupancy), 64'd4);
        chk("pc_full_deq", 64'(PC), 64'h1C000014);
        run(0, 1, 6);
        run(1, 1, 3);

        // Branch redirect with three entries queued.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        run(1, 0, 3);
        step(0, 0, 1, 1, 1, 32'h0, 32'h1C000100, $urandom);
        #1;
        chk("rv_br", 64'(right_valid), 64'd0);
        chk("pc_br", 64'(PC), 64'h1C000100);
        run(1, 1, 3);

        // Exception flush beats a simultaneous branch.
        run(1, 0, 2);
        step(0, 1, 1, 1, 1, 32'h1C008000, 32'h1C000100, $urandom);
        #1;
        chk("pc_flush", 64'(PC), 64'h1C008000);
        chk("occ_flush", 64'(occupancy), 64'd0);

        // Memory stalls on alternate cycles, then a mid-stream reset.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            step(0, 0, 0, (i % 2) == 0, 1, 0, 0, $urandom);
        #1;
        chk("pc_toggle", 64'(PC), 64'h1C00000C);
        step(1, 0, 0, 1, 1, 0, 0, $urandom);
        #1;
        chk("pc_midrst", 64'(PC), 64'h1C000000);
        chk("occ_midrst", 64'(occupancy), 64'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 100) == 0, ($urandom % 20) == 0,
                 ($urandom % 15) == 0, ($urandom % 4) != 0,
                 ($urandom % 2) == 0,
                 {$urandom} & 32'hFFFF_FFFC, {$urandom} & 32'hFFFF_FFFC,
                 $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
